// File: rtl/sram_wr_ctl.sv
// Write-request FIFO draining to an SRAM write port via a held output stage.
// Optional WR_PARITY_EN adds registered even parity on sram_wpar.
module sram_wr_ctl #(
  parameter int sg_data_width     = 64,
  parameter int sg_address_width  = 12,
  parameter int sg_des_width      = 4,
  parameter int sg_priority_width = 3,
  parameter int fifo_depth        = 8,
  parameter int sram_depth        = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         request,
  input  logic [sg_priority_width-1:0] wr_priority,
  input  logic [sg_des_width-1:0]      des_port,
  input  logic [sg_address_width-1:0]  address_write,
  input  logic [sg_data_width-1:0]     data_write,
  output logic                         grant,
  output logic                         sram_we,
  output logic [sg_address_width-1:0]  sram_addr,
  output logic [sg_data_width-1:0]     sram_wdata,
  output logic                         sram_wpar,
  input  logic                         sram_ready,
  output logic                         wr_done,
  output logic [sg_des_width-1:0]      wr_done_port,
  output logic [sg_priority_width-1:0] wr_done_prio,
  output logic                         addr_err,
  output logic [$clog2(fifo_depth):0]  fifo_level
);

  localparam int PTRW = $clog2(fifo_depth);
  localparam int LW   = PTRW + 1;

  typedef struct packed {
    logic [sg_priority_width-1:0] prio;
    logic [sg_des_width-1:0]      port;
    logic [sg_address_width-1:0]  addr;
    logic [sg_data_width-1:0]     data;
  } ent_t;

  typedef enum logic {S_IDLE, S_WRITE} st_t;

  ent_t                         r_mem [fifo_depth];
  logic [PTRW-1:0]              r_wptr;
  logic [PTRW-1:0]              r_rptr;
  logic [LW-1:0]                r_level;
  st_t                          r_st;
  st_t                          w_nxt;
  logic [sg_address_width-1:0]  r_addr;
  logic [sg_data_width-1:0]     r_wdata;
  logic [sg_des_width-1:0]      r_port;
  logic [sg_priority_width-1:0] r_prio;
  logic                         r_done;
  logic [sg_des_width-1:0]      r_done_port;
  logic [sg_priority_width-1:0] r_done_prio;
  logic                         r_err;

  logic w_full;
  logic w_empty;
  logic w_acc;
  logic w_in_range;
  logic w_push;
  logic w_pop;
  logic w_done;
  ent_t w_head;
  ent_t w_new;

  assign w_full     = (r_level == LW'(fifo_depth));
  assign w_empty    = (r_level == '0);
  assign grant      = rst & ~w_full;
  assign w_acc      = request & grant;
  assign w_in_range = (32'(address_write) < 32'(sram_depth));
  assign w_push     = w_acc & w_in_range;
  assign w_head     = r_mem[r_rptr];
  assign w_new      = '{wr_priority, des_port,
                        address_write, data_write};

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_st <= S_IDLE;
    else      r_st <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_st;
    w_pop  = 1'b0;
    w_done = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          w_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (sram_ready) begin
          w_done = 1'b1;
          if (!w_empty) w_pop = 1'b1;
          else          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_port  <= '0;
      r_prio  <= '0;
    end else if (w_pop) begin
      r_addr  <= w_head.addr;
      r_wdata <= w_head.data;
      r_port  <= w_head.port;
      r_prio  <= w_head.prio;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done      <= 1'b0;
      r_done_port <= '0;
      r_done_prio <= '0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_done;
      r_err  <= w_acc & ~w_in_range;
      if (w_done) begin
        r_done_port <= r_port;
        r_done_prio <= r_prio;
      end
    end
  end

`ifdef WR_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_par <= 1'b0;
    else if (w_pop) r_par <= ^w_head.data;
  end

  assign sram_wpar = r_par;
`else
  assign sram_wpar = 1'b0;
`endif

  assign sram_we      = (r_st == S_WRITE);
  assign sram_addr    = r_addr;
  assign sram_wdata   = r_wdata;
  assign wr_done      = r_done;
  assign wr_done_port = r_done_port;
  assign wr_done_prio = r_done_prio;
  assign addr_err     = r_err;
  assign fifo_level   = r_level;

endmodule

// File: tb/tb_sram_wr_ctl.sv
// Directed bench for sram_wr_ctl (built with sram_depth=2048).
module tb_sram_wr_ctl;

`ifdef WR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        request = 1'b0;
  logic [2:0]  wr_priority = '0;
  logic [3:0]  des_port = '0;
  logic [11:0] address_write = '0;
  logic [63:0] data_write = '0;
  logic        grant;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [63:0] sram_wdata;
  logic        sram_wpar;
  logic        sram_ready = 1'b0;
  logic        wr_done;
  logic [3:0]  wr_done_port;
  logic [2:0]  wr_done_prio;
  logic        addr_err;
  logic [3:0]  fifo_level;

  int n_run = 0;
  int n_fail = 0;

  sram_wr_ctl #(.sram_depth(2048)) dut (
    .clk(clk), .rst(rst), .request(request),
    .wr_priority(wr_priority), .des_port(des_port),
    .address_write(address_write), .data_write(data_write),
    .grant(grant), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wpar(sram_wpar),
    .sram_ready(sram_ready), .wr_done(wr_done),
    .wr_done_port(wr_done_port), .wr_done_prio(wr_done_prio),
    .addr_err(addr_err), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [11:0] a, input logic [63:0] d,
                     input logic [3:0] p, input logic [2:0] pr);
    request       = 1'b1;
    address_write = a;
    data_write    = d;
    des_port      = p;
    wr_priority   = pr;
  endtask

  function automatic logic par(input logic [63:0] d);
    return PAR_EN ? ^d : 1'b0;
  endfunction

  int n;
  int dones;

  initial begin
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_wpar", sram_wpar, 0);
    step();
    rst = 1'b1;
    #1;
    chk("rel_grant", grant, 1);

    // single write, two-edge latency
    sram_ready = 1'b1;
    req(12'h010, 64'hDEADBEEF_00000001, 4'd3, 3'd5);
    step();
    request = 1'b0;
    chk("s_level1", fifo_level, 1);
    chk("s_we0", sram_we, 0);
    step();
    chk("s_we1", sram_we, 1);
    chk("s_addr", sram_addr, 64'h010);
    chk("s_data", sram_wdata, 64'hDEADBEEF_00000001);
    chk("s_par", sram_wpar, par(64'hDEADBEEF_00000001));
    chk("s_level0", fifo_level, 0);
    step();
    chk("s_we_off", sram_we, 0);
    chk("s_done", wr_done, 1);
    chk("s_dport", wr_done_port, 3);
    chk("s_dprio", wr_done_prio, 5);
    step();
    chk("s_done_off", wr_done, 0);

    // back-pressure: A goes to output stage, B and C queue
    sram_ready = 1'b0;
    req(12'h100, 64'hA, 4'd1, 3'd1);
    step();
    req(12'h101, 64'hB, 4'd2, 3'd2);
    step();
    req(12'h102, 64'hC, 4'd3, 3'd3);
    step();
    request = 1'b0;
    chk("bp_level", fifo_level, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_we", sram_we, 1);
      chk("bp_hold_addr", sram_addr, 64'h100);
      chk("bp_hold_done", wr_done, 0);
      step();
    end
    sram_ready = 1'b1;
    step();
    chk("bp_addrB", sram_addr, 64'h101);
    chk("bp_doneA", wr_done, 1);
    chk("bp_portA", wr_done_port, 1);
    chk("bp_lvl1", fifo_level, 1);
    step();
    chk("bp_addrC", sram_addr, 64'h102);
    chk("bp_dataC", sram_wdata, 64'hC);
    chk("bp_portB", wr_done_port, 2);
    chk("bp_lvl0", fifo_level, 0);
    step();
    chk("bp_we_off", sram_we, 0);
    chk("bp_portC", wr_done_port, 3);
    chk("bp_prioC", wr_done_prio, 3);
    step();

    // full: one entry sits in the output stage, eight in the FIFO
    sram_ready = 1'b0;
    req(12'h200, 64'h5, 4'd4, 3'd4);
    n = 0;
    while (grant && n < 20) begin
      step();
      n++;
    end
    chk("full_accepts", n, 9);
    chk("full_level", fifo_level, 8);
    chk("full_grant", grant, 0);
    step();
    chk("full_no_push", fifo_level, 8);
    sram_ready = 1'b1;
    step();
    chk("full_pop_lvl", fifo_level, 7);
    chk("full_regrant", grant, 1);
    request = 1'b0;
    n = 0;
    while ((sram_we || fifo_level != 0) && n < 30) begin
      step();
      n++;
    end
    chk("full_drained", n < 30, 1);

    // address range with sram_depth = 2048
    step();
    req(12'h800, 64'h77, 4'd5, 3'd6);
    step();
    request = 1'b0;
    chk("ar_err", addr_err, 1);
    chk("ar_level", fifo_level, 0);
    step();
    chk("ar_err_off", addr_err, 0);
    chk("ar_no_we", sram_we, 0);
    req(12'h7FF, 64'h1, 4'd6, 3'd2);
    step();
    request = 1'b0;
    chk("ar_ok_err", addr_err, 0);
    chk("ar_ok_lvl", fifo_level, 1);
    step();
    chk("ar_ok_we", sram_we, 1);
    chk("ar_ok_addr", sram_addr, 64'h7FF);
    chk("par_1", sram_wpar, par(64'h1));
    step();
    chk("ar_ok_done", wr_done, 1);
    req(12'h300, 64'h3, 4'd1, 3'd1);
    step();
    request = 1'b0;
    step();
    chk("par_3", sram_wpar, par(64'h3));
    chk("par_3_we", sram_we, 1);
    step();
    step();

    // async reset mid-write with four queued
    sram_ready = 1'b0;
    req(12'h400, 64'hF0, 4'd7, 3'd7);
    for (int i = 0; i < 5; i++) step();
    request = 1'b0;
    chk("ar_q_level", fifo_level, 4);
    chk("ar_q_we", sram_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", sram_we, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_grant", grant, 0);
    #1;
    rst = 1'b1;
    sram_ready = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      dones += int'(wr_done) + int'(sram_we);
    end
    chk("arst_no_done", dones, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
